toggle_hs_responder: RTL and testbench
======================================

// Module: toggle_hs_responder
// PURPOSE
//  Responder end of a two-phase (toggle) request/acknowledge link. The initiator
//  signals each new word by inverting req_tog and holds req_data stable. This
//  block synchronises req_tog, detects the toggle and captures req_data. It then
//  presents the word to a local consumer on a valid/ready port, and inverts
//  ack_tog once the consumer has taken the word.
// PARAMETERS
//  WIDTH        8  data word width in bits
//  SYNC_STAGES  2  flops in the req_tog synchroniser chain; minimum 2
// PORTS
//  clk        in   1      clock, rising edge
//  clrn       in   1      reset, asynchronous, active-low
//  req_tog    in   1      request toggle from initiator; may be asynchronous to clk
//  req_data   in   WIDTH  bundled data; initiator holds it stable from before req_tog flips until it sees ack_tog flip
//  ack_tog    out  1      acknowledge toggle to initiator; registered
//  out_data   out  WIDTH  captured word; registered
//  out_valid  out  1      out_data holds an unconsumed word
//  out_ready  in   1      consumer accepts the word when out_valid && out_ready at a clk edge
//  err        out  1      sticky protocol-violation flag
//  xfer_cnt   out  16     completed-transfer count; present only with TOGGLE_HS_CNT_EN
// BEHAVIOUR
//  Reset (clrn=0, acts immediately):
//   - sync chain = 0, req_prev = 0, state = IDLE
//   - ack_tog = 0, out_valid = 0, out_data = 0, err = 0, xfer_cnt = 0
//  Toggle detect:
//   - req_s is the last stage of the sync chain
//   - edge = (req_s != req_prev)
//   - req_prev <= req_s every cycle
//  FSM, two states:
//   - IDLE: out_valid = 0. On edge: out_data <= req_data, out_valid <= 1, go to HOLD.
//   - HOLD: out_valid = 1, out_data held. When out_valid && out_ready:
//       ack_tog <= ~ack_tog, out_valid <= 0, go to IDLE.
//  Latency:
//   - req_tog first sampled at clk edge N -> out_valid = 1 after edge N+SYNC_STAGES.
//   - If out_ready is already 1, ack_tog flips at edge N+SYNC_STAGES+1.
//   - Minimum out_valid pulse is 1 cycle. Throughput is set by the initiator's
//     round trip; one word at a time, no buffering.
//  Backpressure:
//   - out_valid and out_data stay stable while out_ready = 0, for any duration.
//   - ack_tog does not change until the handshake completes.
//  Boundary conditions:
//   - Edge seen in HOLD is a protocol violation:
//       err <= 1 (sticky until reset); edge discarded (req_prev still updates);
//       out_data unchanged; exactly one ack_tog flip for the held word.
//   - Edge in IDLE on the same cycle that HOLD exits cannot occur: the FSM is in
//     one state per cycle.
//   - clrn asserted mid-HOLD: word lost, all outputs return to reset values.
//   - Both link ends must be reset together.
//   - If req_tog = 1 when clrn releases, the chain (reset to 0) sees an edge and
//     treats it as a request. This is intended, since the initiator's reset state is 0.
//  Width rules: out_data is exactly WIDTH bits, no extension.
// CONFIGURATION
//  TOGGLE_HS_CNT_EN defined:
//   - xfer_cnt port exists.
//   - It increments by 1 on each completed handshake (out_valid && out_ready).
//   - It wraps from 16'hFFFF to 16'h0000.
//  TOGGLE_HS_CNT_EN undefined:
//   - xfer_cnt port and its register are absent.
//   - All other behaviour is identical.
// TESTING (WIDTH=8, SYNC_STAGES=2)
//  1. Hold clrn=0 with req_tog=0
//     -> ack_tog=0, out_valid=0, out_data=8'h00, err=0 (xfer_cnt=0 if enabled).
//  2. req_data=8'hA5; req_tog 0->1 before edge N; out_ready=1
//     -> out_valid=1, out_data=8'hA5 after edge N+2;
//     -> ack_tog 0->1 and out_valid=0 after edge N+3.
//  3. Same as 2 but out_ready=0 for 10 cycles
//     -> out_valid=1, out_data=8'hA5, ack_tog=0 throughout;
//     -> raise out_ready: ack_tog flips at the next edge.
//  4. Second transfer: req_data=8'h3C, req_tog 1->0
//     -> out_data=8'h3C, ack_tog 1->0; err stays 0.
//  5. Flip req_tog twice with no handshake (out_ready=0)
//     -> err=1 and stays 1; out_data keeps the first word;
//     -> after out_ready=1, ack_tog flips exactly once.
//  6. clrn pulsed low while out_valid=1
//     -> outputs go to reset values immediately.
//     With TOGGLE_HS_CNT_EN: 3 transfers -> xfer_cnt=3; force 16'hFFFF + 1 transfer -> 16'h0000.

Source files
------------

// File: rtl/toggle_hs_responder.sv
// Responder end of a two-phase toggle req/ack link; presents each word on a valid/ready port.
// Optional completed-transfer counter (xfer_cnt) enabled by defining TOGGLE_HS_CNT_EN.
module toggle_hs_responder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req_tog,
  input  logic [WIDTH-1:0] req_data,
  output logic             ack_tog,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
`ifdef TOGGLE_HS_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 req_prev;
  logic                 req_s_c;
  logic                 req_edge_c;
  logic                 hs_c;
  logic                 ack_d;
  logic                 valid_d;
  logic [WIDTH-1:0]     data_d;
  logic                 err_d;

  assign req_s_c    = sync_q[SYNC_STAGES-1];
  assign req_edge_c = (req_s_c != req_prev);
  assign hs_c       = (state_q == HOLD) && out_valid && out_ready;

  // req_tog synchroniser and previous-value register for toggle detection
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q   <= '0;
      req_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], req_tog};
      req_prev <= req_s_c;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ack_d   = ack_tog;
    valid_d = out_valid;
    data_d  = out_data;
    err_d   = err;
    case (state_q)
      IDLE: begin
        if (req_edge_c) begin
          data_d  = req_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A new toggle while a word is still held is discarded and flagged
        if (req_edge_c) begin
          err_d = 1'b1;
        end
        if (hs_c) begin
          ack_d   = ~ack_tog;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      ack_tog   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_tog   <= ack_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      err       <= err_d;
    end
  end

`ifdef TOGGLE_HS_CNT_EN
  // Completed-handshake counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      xfer_cnt <= '0;
    end else if (hs_c) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_toggle_hs_responder.sv
// Directed self-checking bench for toggle_hs_responder (WIDTH=8, SYNC_STAGES=2).
// Counter checks run only when TOGGLE_HS_CNT_EN is defined.
module tb_toggle_hs_responder;

  logic       clk = 1'b0;
  logic       clrn;
  logic       req_tog;
  logic [7:0] req_data;
  logic       ack_tog;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err;
`ifdef TOGGLE_HS_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  toggle_hs_responder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_tog   (req_tog),
    .req_data  (req_data),
    .ack_tog   (ack_tog),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
`ifdef TOGGLE_HS_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are stable 1ns after it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Observed vector is {ack_tog, out_valid, out_data, err}
  task automatic test_reset;
    clrn = 1'b0; req_tog = 1'b0; req_data = 8'h00; out_ready = 1'b0;
    tick(3);
    if ({ack_tog, out_valid, out_data, err} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      $display("FAIL reset_state got=%h exp=%h", {ack_tog, out_valid, out_data, err}, 11'h000);
      n_err++;
    end
    n_vec++;
    clrn = 1'b1;
    tick(1);
  endtask

  task automatic test_basic;
    req_data = 8'hA5; req_tog = 1'b1; out_ready = 1'b1;
    tick(2);
    if (out_valid !== 1'b0) begin
      $display("FAIL basic_early_valid got=%b exp=0", out_valid); n_err++;
    end
    n_vec++;
    tick(1);
    if ({ack_tog, out_valid, out_data, err} !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
      $display("FAIL basic_present got=%h exp=%h", {ack_tog, out_valid, out_data, err}, {1'b0, 1'b1, 8'hA5, 1'b0});
      n_err++;
    end
    n_vec++;
    tick(1);
    if ({ack_tog, out_valid} !== 2'b10) begin
      $display("FAIL basic_ack got=%b exp=10", {ack_tog, out_valid}); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; req_data = 8'hA5; req_tog = 1'b0;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      if ({ack_tog, out_valid, out_data} !== {1'b1, 1'b1, 8'hA5}) begin
        $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {ack_tog, out_valid, out_data}, {1'b1, 1'b1, 8'hA5});
        n_err++;
      end
      n_vec++;
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    if ({ack_tog, out_valid} !== 2'b00) begin
      $display("FAIL bp_release got=%b exp=00", {ack_tog, out_valid}); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_second_xfer;
    req_data = 8'h3C; req_tog = 1'b1; out_ready = 1'b1;
    tick(3);
    if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin
      $display("FAIL second_present got=%h exp=%h", {out_valid, out_data}, {1'b1, 8'h3C}); n_err++;
    end
    n_vec++;
    tick(1);
    if ({ack_tog, out_valid, err} !== 3'b100) begin
      $display("FAIL second_ack got=%b exp=100", {ack_tog, out_valid, err}); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_violation;
    out_ready = 1'b0; req_data = 8'h5A; req_tog = 1'b0;
    tick(3);
    if ({out_valid, out_data, err} !== {1'b1, 8'h5A, 1'b0}) begin
      $display("FAIL viol_first got=%h exp=%h", {out_valid, out_data, err}, {1'b1, 8'h5A, 1'b0}); n_err++;
    end
    n_vec++;
    req_data = 8'h77; req_tog = 1'b1;
    tick(3);
    if ({ack_tog, out_valid, out_data, err} !== {1'b1, 1'b1, 8'h5A, 1'b1}) begin
      $display("FAIL viol_flag got=%h exp=%h", {ack_tog, out_valid, out_data, err}, {1'b1, 1'b1, 8'h5A, 1'b1});
      n_err++;
    end
    n_vec++;
    out_ready = 1'b1;
    tick(1);
    if ({ack_tog, out_valid, err} !== 3'b001) begin
      $display("FAIL viol_ack got=%b exp=001", {ack_tog, out_valid, err}); n_err++;
    end
    n_vec++;
    tick(5);
    if ({ack_tog, out_valid, err} !== 3'b001) begin
      $display("FAIL viol_single_ack got=%b exp=001", {ack_tog, out_valid, err}); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_reset_mid_hold;
    out_ready = 1'b0; req_data = 8'hC3; req_tog = 1'b0;
    tick(3);
    if ({out_valid, out_data} !== {1'b1, 8'hC3}) begin
      $display("FAIL rst_hold_pre got=%h exp=%h", {out_valid, out_data}, {1'b1, 8'hC3}); n_err++;
    end
    n_vec++;
    #2 clrn = 1'b0;
    #1;
    if ({ack_tog, out_valid, out_data, err} !== 11'h000) begin
      $display("FAIL rst_async got=%h exp=%h", {ack_tog, out_valid, out_data, err}, 11'h000); n_err++;
    end
    n_vec++;
    tick(1);
    clrn = 1'b1;
    out_ready = 1'b1;
    tick(4);
    if ({ack_tog, out_valid, out_data, err} !== 11'h000) begin
      $display("FAIL rst_after got=%h exp=%h", {ack_tog, out_valid, out_data, err}, 11'h000); n_err++;
    end
    n_vec++;
  endtask

`ifdef TOGGLE_HS_CNT_EN
  task automatic do_xfer(input logic [7:0] d);
    req_data = d; req_tog = ~req_tog; out_ready = 1'b1;
    tick(5);
  endtask

  task automatic test_counter;
    if (xfer_cnt !== 16'h0000) begin
      $display("FAIL cnt_reset got=%h exp=0000", xfer_cnt); n_err++;
    end
    n_vec++;
    do_xfer(8'h11); do_xfer(8'h22); do_xfer(8'h33);
    if (xfer_cnt !== 16'h0003) begin
      $display("FAIL cnt_three got=%h exp=0003", xfer_cnt); n_err++;
    end
    n_vec++;
    force dut.xfer_cnt = 16'hFFFF;
    tick(1);
    release dut.xfer_cnt;
    do_xfer(8'h44);
    if (xfer_cnt !== 16'h0000) begin
      $display("FAIL cnt_wrap got=%h exp=0000", xfer_cnt); n_err++;
    end
    n_vec++;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_second_xfer;
    test_violation;
    test_reset_mid_hold;
`ifdef TOGGLE_HS_CNT_EN
    test_counter;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
